// File: rtl/conv_result_collector.sv
// ----------------------------------------------------------------------------
// conv_result_collector
//
// Write-side companion of the display sequencer. Takes the convolution
// engine's result stream one byte per valid/ready handshake and fills eight
// parallel holding registers in arrival order. When the eighth byte lands it
// pulses start_d for one cycle, then freezes the registers until cleared.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low; clears all state
//   clear               synchronous re-arm for a new 8-result frame
//   in_valid, in_data   result byte from the convolution engine
//   in_ready            collector can accept in_data this cycle
//   num_A .. num_H      holding registers, slot 0..7 in arrival order
//   start_d             one-cycle pulse: frame complete, start display
//   full                all 8 slots written, frame held
//   count               slots written in the current frame, 0..8
//   overflow            sticky: in_valid seen while in_ready = 0
// ----------------------------------------------------------------------------
module conv_result_collector #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] num_A,
    output logic [DATA_W-1:0] num_B,
    output logic [DATA_W-1:0] num_C,
    output logic [DATA_W-1:0] num_D,
    output logic [DATA_W-1:0] num_E,
    output logic [DATA_W-1:0] num_F,
    output logic [DATA_W-1:0] num_G,
    output logic [DATA_W-1:0] num_H,
    output logic              start_d,
    output logic              full,
    output logic [3:0]        count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] slot [8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FILL;
            count    <= '0;
            overflow <= 1'b0;
            slot     <= '{default: '0};
        end else if (clear) begin
            // Holding registers are left alone so the display is not blanked;
            // a sample arriving with clear is neither accepted nor flagged.
            state    <= S_FILL;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (in_valid) begin
                        slot[count[2:0]] <= in_data;
                        count            <= count + 4'd1;
                        if (count == 4'd7) begin
                            state <= S_START;
                        end
                    end
                end
                S_START: begin
                    if (in_valid) begin
                        overflow <= 1'b1;
                    end
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    if (in_valid) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    state <= S_FILL;
                    count <= '0;
                end
            endcase
        end
    end

    // Handshake and status outputs depend on the state register alone.
    assign in_ready = (state == S_FILL);
    assign start_d  = (state == S_START);
    assign full     = (state == S_START) || (state == S_HOLD);

    assign num_A = slot[0];
    assign num_B = slot[1];
    assign num_C = slot[2];
    assign num_D = slot[3];
    assign num_E = slot[4];
    assign num_F = slot[5];
    assign num_G = slot[6];
    assign num_H = slot[7];

endmodule

// File: tb/tb_conv_result_collector.sv
// ----------------------------------------------------------------------------
// tb_conv_result_collector
//
// Self-checking bench for conv_result_collector. A small reference model
// tracks state, count and overflow; every accepted byte is pushed to a
// scoreboard queue and popped for comparison against the holding registers
// when the frame completes.
// ----------------------------------------------------------------------------
module tb_conv_result_collector;

    localparam int DATA_W = 8;

    logic              clk;
    logic              reset;
    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] num_A, num_B, num_C, num_D, num_E, num_F, num_G, num_H;
    logic              start_d;
    logic              full;
    logic [3:0]        count;
    logic              overflow;

    conv_result_collector #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .num_A    (num_A),
        .num_B    (num_B),
        .num_C    (num_C),
        .num_D    (num_D),
        .num_E    (num_E),
        .num_F    (num_F),
        .num_G    (num_G),
        .num_H    (num_H),
        .start_d  (start_d),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 = fill, 1 = start, 2 = hold
    int          m_state = 0;
    int          m_count = 0;
    logic        m_ovf   = 1'b0;
    logic [7:0]  exp_q [$];

    // start_d pulses observed, sampled on the falling edge
    int start_cnt = 0;
    always @(negedge clk) begin
        if (start_d === 1'b1) start_cnt++;
    end

    function automatic logic [DATA_W-1:0] get_num(input int idx);
        case (idx)
            0: return num_A;
            1: return num_B;
            2: return num_C;
            3: return num_D;
            4: return num_E;
            5: return num_F;
            6: return num_G;
            default: return num_H;
        endcase
    endfunction

    // One clock with the given inputs; leaves time at posedge + 1.
    task automatic tick(input logic v, input logic [7:0] d, input logic c);
        int pre;
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clk);
        pre = m_state;
        if (c) begin
            m_state = 0;
            m_count = 0;
            m_ovf   = 1'b0;
        end else if (pre == 0) begin
            if (v) begin
                exp_q.push_back(d);
                m_count++;
                if (m_count == 8) m_state = 1;
            end
        end else begin
            if (v) m_ovf = 1'b1;
            m_state = 2;
        end
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_count = 0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        model_reset();
        #12;
        checks++;
        if (count !== 4'd0 || start_d !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: count=%0d start_d=%b full=%b overflow=%b, want 0/0/0/0",
                     count, start_d, full, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (get_num(i) !== 8'h00) begin
                failures++;
                $display("FAIL reset_num%0d: got %h want 00", i, get_num(i));
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 8'((i + 1) * 8'h11), 1'b0);
            checks++;
            if (start_d !== (i == 7)) begin
                failures++;
                $display("FAIL b2b_start_d@%0d: got %b want %b", i, start_d, (i == 7));
            end
        end
        checks++;
        if (exp_q.size() != 8) begin
            failures++;
            $display("FAIL b2b_queue: %0d entries want 8", exp_q.size());
        end
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (get_num(i) !== e) begin
                failures++;
                $display("FAIL b2b_num%0d: got %h want %h", i, get_num(i), e);
            end
        end
        checks++;
        if (in_ready !== 1'b0 || full !== 1'b1 || count !== 4'd8) begin
            failures++;
            $display("FAIL b2b_status: in_ready=%b full=%b count=%0d want 0/1/8",
                     in_ready, full, count);
        end
        tick(1'b0, 8'h00, 1'b0);
        checks++;
        if (start_d !== 1'b0 || full !== 1'b1 || count !== 4'd8) begin
            failures++;
            $display("FAIL b2b_hold: start_d=%b full=%b count=%0d want 0/1/8",
                     start_d, full, count);
        end
    endtask

    task automatic test_random_gaps();
        int         s0;
        int         gap;
        logic [7:0] e;
        tick(1'b0, 8'h00, 1'b1);
        s0 = start_cnt;
        for (int i = 0; i < 8; i++) begin
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                tick(1'b0, 8'hEE, 1'b0);
                checks++;
                if (count !== 4'(m_count)) begin
                    failures++;
                    $display("FAIL gap_idle_count: got %0d want %0d", count, m_count);
                end
            end
            tick(1'b1, 8'((i + 1) * 8'h11), 1'b0);
            checks++;
            if (count !== 4'(i + 1)) begin
                failures++;
                $display("FAIL gap_count@%0d: got %0d want %0d", i, count, i + 1);
            end
        end
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (get_num(i) !== e) begin
                failures++;
                $display("FAIL gap_num%0d: got %h want %h", i, get_num(i), e);
            end
        end
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL gap_pulses: saw %0d start_d pulses want 1", start_cnt - s0);
        end
    endtask

    task automatic test_overflow();
        int s0;
        s0 = start_cnt;
        tick(1'b1, 8'hFF, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        checks++;
        if (overflow !== m_ovf || m_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag: got %b want 1", overflow);
        end
        checks++;
        if (num_H !== 8'h88) begin
            failures++;
            $display("FAIL ovf_numH: got %h want 88", num_H);
        end
        checks++;
        if (start_cnt != s0) begin
            failures++;
            $display("FAIL ovf_restart: saw %0d extra start_d pulses want 0", start_cnt - s0);
        end
    endtask

    task automatic test_clear_midframe();
        logic [7:0] e;
        int         s0;
        tick(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'h30 + i), 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        exp_q.delete();
        s0 = start_cnt;
        checks++;
        if (count !== 4'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_status: count=%0d in_ready=%b want 0/1", count, in_ready);
        end
        for (int i = 0; i < 8; i++) tick(1'b1, 8'(8'hA0 + i), 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (get_num(i) !== e) begin
                failures++;
                $display("FAIL clr_num%0d: got %h want %h", i, get_num(i), e);
            end
        end
        checks++;
        if (overflow !== 1'b0 || start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL clr_frame: overflow=%b pulses=%0d want 0/1", overflow, start_cnt - s0);
        end
    endtask

    task automatic test_reset_midframe();
        int         s0;
        logic [7:0] e;
        tick(1'b0, 8'h00, 1'b1);
        exp_q.delete();
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'hC0 + i), 1'b0);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (count !== 4'd0 || start_d !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_status: count=%0d start_d=%b want 0/0", count, start_d);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (get_num(i) !== 8'h00) begin
                failures++;
                $display("FAIL rst_mid_num%0d: got %h want 00", i, get_num(i));
            end
        end
        #13;
        reset = 1'b1;
        checks++;
        if (start_cnt != s0) begin
            failures++;
            $display("FAIL rst_mid_nostart: saw %0d start_d pulses want 0", start_cnt - s0);
        end
        for (int i = 0; i < 8; i++) tick(1'b1, 8'(8'h51 + i), 1'b0);
        checks++;
        if (start_d !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_frame_start: start_d=%b want 1", start_d);
        end
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (get_num(i) !== e) begin
                failures++;
                $display("FAIL rst_mid_num_after%0d: got %h want %h", i, get_num(i), e);
            end
        end
    endtask

    task automatic test_clear_with_valid();
        logic [7:0] old_a;
        logic [7:0] e;
        tick(1'b0, 8'h00, 1'b1);
        exp_q.delete();
        old_a = 8'h51;
        tick(1'b1, 8'h5A, 1'b1);
        checks++;
        if (count !== 4'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL clrv_status: count=%0d overflow=%b want 0/0", count, overflow);
        end
        checks++;
        if (num_A !== old_a) begin
            failures++;
            $display("FAIL clrv_numA: got %h want %h", num_A, old_a);
        end
        tick(1'b1, 8'h3C, 1'b0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        checks++;
        if (num_A !== e || count !== 4'd1) begin
            failures++;
            $display("FAIL clrv_next: numA=%h count=%0d want %h/1", num_A, count, e);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_random_gaps();
        test_clear_midframe();
        test_reset_midframe();
        test_clear_with_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
